// File: rtl/dec_scan_ctrl_if.sv
// Handshake bundle between a scan requester and the decoder scan controller.
// The master drives the scan requests; the slave returns decoder select/enable and status.
interface dec_scan_ctrl_if;
   logic       start;
   logic       stop;
   logic       mode;
   logic [3:0] mask;
   logic [1:0] A;
   logic       En;
   logic       busy;
   logic       done;
   logic       frame;

   modport master (
      output start, stop, mode, mask,
      input  A, En, busy, done, frame
   );

   modport slave (
      input  start, stop, mode, mask,
      output A, En, busy, done, frame
   );
endinterface

// File: rtl/dec_scan_ctrl.sv
// Scan controller for the 2-to-4 decoder: walks the enabled channels with a blank
// gap before each active window so two decoder lines are never high together.
module dec_scan_ctrl #(
   parameter int DWELL = 4,
   parameter int BLANK = 1
) (
   input logic           clk_i,
   input logic           rst_i,
   dec_scan_ctrl_if.slave bus
);

   localparam int MAXLEN = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBlank,
      StActive
   } scanState_e;

   scanState_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    a_q, a_d;
   logic          en_q, en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          frame_q, frame_d;
   logic [3:0]    maskLat_q, maskLat_d;
   logic          modeLat_q, modeLat_d;

   logic [1:0]    lowestIn;
   logic [1:0]    nextCh;
   logic          hasNext;

   function automatic logic [1:0] lowestSet(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Smallest enabled channel strictly above the current one; flag clear means wrap.
   function automatic logic [2:0] nextAbove(input logic [3:0] m, input logic [1:0] cur);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   assign lowestIn          = lowestSet(bus.mask);
   assign {hasNext, nextCh} = nextAbove(maskLat_q, a_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         a_q       <= 2'b00;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         frame_q   <= 1'b0;
         maskLat_q <= 4'b0000;
         modeLat_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         frame_q   <= frame_d;
         maskLat_q <= maskLat_d;
         modeLat_q <= modeLat_d;
      end
   end

   // A is only ever reloaded on the way into StBlank, which keeps En low across every change.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      en_d      = en_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      frame_d   = 1'b0;
      maskLat_d = maskLat_q;
      modeLat_d = modeLat_q;

      if (bus.stop) begin
         state_d = StIdle;
         cnt_d   = '0;
         en_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start && (bus.mask != 4'b0000)) begin
                  maskLat_d = bus.mask;
                  modeLat_d = bus.mode;
                  a_d       = lowestIn;
                  state_d   = StBlank;
                  cnt_d     = '0;
                  en_d      = 1'b0;
                  busy_d    = 1'b1;
               end
            end
            StBlank: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = StActive;
                  cnt_d   = '0;
                  en_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StActive: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_d = '0;
                  en_d  = 1'b0;
                  if (hasNext) begin
                     a_d     = nextCh;
                     state_d = StBlank;
                  end else if (modeLat_q) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = StIdle;
                  end else begin
                     frame_d   = 1'b1;
                     maskLat_d = bus.mask;
                     if (bus.mask != 4'b0000) begin
                        a_d     = lowestIn;
                        state_d = StBlank;
                     end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
               en_d    = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign bus.A     = a_q;
   assign bus.En    = en_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.frame = frame_q;

   aStableWhileEn: assert property (@(posedge clk_i) disable iff (rst_i)
      en_q |=> (!en_q || $stable(a_q)));

endmodule

// File: doc/dec_scan_ctrl.md
# dec_scan_ctrl

Sequential scan controller that drives the select/enable inputs of the team's 2-to-4 decoder (`A[1:0]`, `En`). It steps through a maskable set of four channels (display digits, keypad rows, chip selects), holding each for a programmable dwell with a blanking gap before it, so that the decoder output never glitches between two active lines. It runs in single-sweep or continuous mode and reports sweep completion and frame wrap.

## Interface
- `DWELL`, default 4: cycles `En` stays high per channel; legal values ≥1.
- `BLANK`, default 1: cycles `En` stays low before each channel's active window; legal values ≥1.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a scan; sampled each cycle.
- `stop`  in  1  abort the scan; sampled each cycle.
- `mode`  in  1  0 = continuous, 1 = single sweep; sampled with `start`.
- `mask`  in  4  bit i = 1 enables channel i; sampled at start and at each frame wrap.
- `A`  out  2  channel index to the decoder.
- `En`  out  1  decoder enable.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse at the end of a single sweep.
- `frame`  out  1  one-cycle pulse at each continuous-mode wrap.

## Operation
- All outputs are registered. Reset values: `A`=00, `En`=0, `busy`=0, `done`=0, `frame`=0, state IDLE, latched mask 0000.
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - If `start`=1, `stop`=0 and `mask`≠0000: latch `mask` and `mode`, load `A` with the lowest set mask bit, and go to BLANK.
  - `start` with `mask`=0000 is ignored.
  - `A` holds its last value.
- BLANK: `En`=0 and `A` is stable. After `BLANK` cycles, go to ACTIVE.
- ACTIVE: `En`=1 and `A` is stable. After `DWELL` cycles:
  - If `A` is not the highest set bit of the latched mask: load `A` with the next higher set bit and go to BLANK.
  - Otherwise (wrap), in single mode: pulse `done`, then go to IDLE.
  - Otherwise (wrap), in continuous mode: pulse `frame` and relatch `mask`.
    - New mask ≠0000: load `A` with its lowest set bit and go to BLANK.
    - New mask =0000: go to IDLE.
- `A` changes only on entry to BLANK. `A` never changes while `En`=1.
- `stop` has priority over everything except `rst`. On the next edge: IDLE, `En`=0, `busy`=0, no `done` or `frame`, `A` held.
- `start` while busy is ignored. `start` and `stop` in the same IDLE cycle: the block stays IDLE.
- A single-bit mask repeats that channel, with a blank gap before each active window.
- `mask` changes while busy have no effect until the next wrap.
- `rst` mid-scan: on the next edge all outputs take their reset values.

## Timing
- Let `start` be sampled at edge k. Then `busy`=1 and `A`=first channel from edge k, and `En`=0 for cycles k..k+BLANK−1.
- `En`=1 for cycles k+BLANK..k+BLANK+DWELL−1.
- Per channel: `BLANK`+`DWELL` cycles. With N enabled channels, one sweep takes N·(BLANK+DWELL) cycles.
- Single sweep: `done`=1 and `busy`=0 in the cycle immediately after the last ACTIVE cycle. `done` lasts exactly 1 cycle.
- Continuous mode: `frame`=1 in the first BLANK cycle of the new frame, for 1 cycle.
  - If the relatched mask is 0000, `frame`=1 in the first IDLE cycle instead, together with `busy`=0.
- `stop` sampled at edge j: `En`=0 and `busy`=0 from cycle j.
- IDLE→BLANK latency after `start`: 0 cycles (registered at the sampling edge).

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `start`=1 → `A`=00, `En`=0, `busy`=0, `done`=0, `frame`=0 throughout and after release (`start` low at release).
- Single sweep, `DWELL`=4, `BLANK`=1, `mask`=1111, `start` pulse → `A` = 00, 01, 10, 11, each with 1 `En`-low cycle then 4 `En`-high cycles. `busy` lasts 20 cycles. Then `done`=1 for 1 cycle. No `A` change ever coincides with `En`=1.
- Continuous, `mask`=1010 → `A` alternates 01 then 11. `frame` pulses every 10 cycles. Change `mask` to 0100 mid-frame → only channel 10 is scanned from the next wrap on.
- Continuous, change `mask` to 0000 mid-frame → the frame completes, then `frame` pulses, `busy`=0 and the block is IDLE. A following `start` with `mask`=0000 → still IDLE.
- `stop` during cycle 2 of ACTIVE on channel 01 → `En`=0 and `busy`=0 next cycle, `A` stays 01, no `done`. `start` while busy → no effect on the sequence. `start`+`stop` together in IDLE → stays IDLE.
- `rst` asserted mid-ACTIVE → next cycle all outputs are at reset values. After release, a fresh `start` with `mask`=0001 → `A`=00, `En` pattern 1 cycle low, 4 cycles high, repeating in continuous mode.
